mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have reset  input  1  reset: synchronous, active-high; clock clk.
REQ-003 SHALL have EXE_to_MEM_valid  input  1  upstream instruction valid.
REQ-004 SHALL have EXE_MEM_reg  input  74  {pc[73:42], load_op[41:39], res_from_mem[38], gr_we[37], dest[36:32], alu_result[31:0]}.
REQ-005 SHALL have MEM_allow_in  output  1  stage can accept a new instruction this cycle.
REQ-006 SHALL have data_sram_rdata  input  32  synchronous data-SRAM read word; read request issued in EXE.
REQ-007 SHALL have WB_allow_in  input  1  downstream accept.
REQ-008 SHALL have MEM_to_WB_valid  output  1  payload to WB valid.
REQ-009 SHALL have MEM_WB_reg  output  70  {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}.
REQ-010 SHALL have MEM_fwd_bus  output  38  {fwd_we[37], dest[36:32], final_result[31:0]} to decode for bypass.

Function
REQ-011 SHALL use MEM_ready_go = 1; MEM_allow_in = !MEM_valid || (MEM_ready_go && WB_allow_in).
REQ-012 SHALL update MEM_valid <= EXE_to_MEM_valid on every clock edge where MEM_allow_in = 1; otherwise hold.
REQ-013 SHALL latch all EXE_MEM_reg fields only when EXE_to_MEM_valid && MEM_allow_in.
REQ-014 SHALL drive MEM_to_WB_valid = MEM_valid && MEM_ready_go.
REQ-015 SHALL treat data_sram_rdata as valid only in the first cycle after an instruction is latched (entry cycle).
REQ-016 SHALL, in the entry cycle, when WB_allow_in = 0, capture data_sram_rdata into rdata_hold and set hold_vld.
REQ-017 SHALL use rdata_hold as the load word while hold_vld = 1, else data_sram_rdata.
REQ-018 SHALL clear hold_vld on any latch of a new instruction, and when MEM_valid deasserts.
REQ-019 SHALL decode load_op: 000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu; 101-111 treated as ld.w.
REQ-020 SHALL select the byte by alu_result[1:0] (lane 0 = bits 7:0) and the halfword by alu_result[1] (0 = bits 15:0).
REQ-021 SHALL sign-extend ld.b/ld.h, zero-extend ld.bu/ld.hu, and pass the full word for ld.w.
REQ-022 SHALL set final_result = res_from_mem ? extended load data : alu_result.
REQ-023 SHALL drive fwd_we = MEM_valid && gr_we; dest and final_result on MEM_fwd_bus identical to MEM_WB_reg.
REQ-024 SHALL pass pc, gr_we and dest unchanged from latch to MEM_WB_reg.
REQ-025 SHALL ignore alignment faults: misaligned halfword/word addresses use the lane selection above with no trap.
REQ-026 SHALL support back-to-back instructions at one per cycle when WB_allow_in = 1.

Reset
REQ-027 SHALL on reset force MEM_valid = 0, hold_vld = 0, all latched payload and rdata_hold = 0.
REQ-028 SHALL therefore present MEM_to_WB_valid = 0, MEM_WB_reg = 0, MEM_fwd_bus = 0 and MEM_allow_in = 1 in the cycle after reset.
REQ-029 SHALL let reset override a simultaneous EXE_to_MEM_valid; the in-flight instruction is discarded.

Structure
REQ-030 SHALL place the load_op encodings and bus widths (74, 70, 38) in the shared pipeline package.
REQ-031 SHALL isolate lane selection and extension in one combinational sub-module, load_align.

Verification
REQ-032 SHALL test a load: ld.b, alu_result=0x1003, rdata=0x80FF_1234, res_from_mem=1 -> final_result=0xFFFF_FF80, MEM_to_WB_valid=1 next cycle.
REQ-033 SHALL test unsigned halfword: ld.hu, alu_result=0x2002, rdata=0x8001_7FFF -> final_result=0x0000_8001; ld.h on the same inputs -> 0xFFFF_8001.
REQ-034 SHALL test a stall: ld.w latched, rdata=0xDEAD_BEEF in entry cycle, WB_allow_in=0 for 3 cycles, rdata driven to 0 afterward -> MEM_WB_reg[31:0] stays 0xDEAD_BEEF, MEM_allow_in=0 throughout.
REQ-035 SHALL test ALU pass-through back-to-back: three non-load ops with gr_we=1 and dest 1,2,3 on consecutive cycles -> three consecutive MEM_to_WB_valid pulses with fwd_we=1 and matching dest/result.
REQ-036 SHALL test reset mid-operation: valid instruction in MEM, reset asserted one cycle -> MEM_to_WB_valid=0, MEM_fwd_bus=0, MEM_allow_in=1 the following cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: bus widths, load encodings
// and the EXE->MEM payload layout.
package mem_stage_pkg;

    localparam int EXE_MEM_W = 74;
    localparam int MEM_WB_W  = 70;
    localparam int FWD_W     = 38;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_HU = 3'b100
    } load_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
    } exe_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane selection and sign/zero extension; misaligned addresses simply
// pick the lane addressed by the low bits, no trap.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[8*addr_i +: 8];
    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = word_i;
        case (load_op_e'(load_op_i))
            LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
            LD_BU:   data_o = {24'd0, byte_sel};
            LD_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EXE payload, aligns the SRAM load word and
// keeps that word alive across WB back-pressure.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 EXE_to_MEM_valid,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_reg,
    output logic                 MEM_allow_in,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 WB_allow_in,
    output logic                 MEM_to_WB_valid,
    output logic [MEM_WB_W-1:0]  MEM_WB_reg,
    output logic [FWD_W-1:0]     MEM_fwd_bus
);

    localparam logic MEM_READY_GO = 1'b1;

    exe_mem_t    pl_q, pl_d;
    logic        valid_q, valid_d;
    logic        entry_q, entry_d;
    logic        hold_vld_q, hold_vld_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;
    logic        latch;
    logic [31:0] load_word, load_data, final_result;

    assign MEM_allow_in    = !valid_q || (MEM_READY_GO && WB_allow_in);
    assign MEM_to_WB_valid = valid_q && MEM_READY_GO;
    assign latch           = EXE_to_MEM_valid && MEM_allow_in;

    // SRAM data is only presented in the entry cycle; a stall there must
    // preserve it until WB takes the instruction.
    always_comb begin
        pl_d         = pl_q;
        valid_d      = valid_q;
        entry_d      = latch;
        hold_vld_d   = hold_vld_q;
        rdata_hold_d = rdata_hold_q;
        if (MEM_allow_in)
            valid_d = EXE_to_MEM_valid;
        if (latch) begin
            pl_d       = exe_mem_t'(EXE_MEM_reg);
            hold_vld_d = 1'b0;
        end else if (MEM_allow_in) begin
            hold_vld_d = 1'b0;
        end else if (entry_q && valid_q && !WB_allow_in) begin
            hold_vld_d   = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pl_q         <= '0;
            valid_q      <= 1'b0;
            entry_q      <= 1'b0;
            hold_vld_q   <= 1'b0;
            rdata_hold_q <= 32'd0;
        end else begin
            pl_q         <= pl_d;
            valid_q      <= valid_d;
            entry_q      <= entry_d;
            hold_vld_q   <= hold_vld_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign load_word = hold_vld_q ? rdata_hold_q : data_sram_rdata;

    load_align u_load_align (
        .load_op_i (pl_q.load_op),
        .addr_i    (pl_q.alu_result[1:0]),
        .word_i    (load_word),
        .data_o    (load_data)
    );

    assign final_result = pl_q.res_from_mem ? load_data : pl_q.alu_result;
    assign MEM_WB_reg   = {pl_q.pc, pl_q.gr_we, pl_q.dest, final_result};
    assign MEM_fwd_bus  = {valid_q && pl_q.gr_we, pl_q.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load vectors, stall/back-to-back/reset
// sequences, then random traffic against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EXE_to_MEM_valid;
    logic [73:0] EXE_MEM_reg;
    logic        MEM_allow_in;
    logic [31:0] data_sram_rdata;
    logic        WB_allow_in;
    logic        MEM_to_WB_valid;
    logic [69:0] MEM_WB_reg;
    logic [37:0] MEM_fwd_bus;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .EXE_MEM_reg      (EXE_MEM_reg),
        .MEM_allow_in     (MEM_allow_in),
        .data_sram_rdata  (data_sram_rdata),
        .WB_allow_in      (WB_allow_in),
        .MEM_to_WB_valid  (MEM_to_WB_valid),
        .MEM_WB_reg       (MEM_WB_reg),
        .MEM_fwd_bus      (MEM_fwd_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rfm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] pc, input logic [2:0] op, input logic rfm,
                       input logic we, input logic [4:0] dest, input logic [31:0] alu);
        EXE_to_MEM_valid = v;
        EXE_MEM_reg      = {pc, op, rfm, we, dest, alu};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        EXE_to_MEM_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Load semantics from plain arithmetic on the word.
    function automatic logic [31:0] ref_final(input logic [2:0] op, input logic [31:0] alu,
                                              input logic [31:0] word, input logic rfm);
        longint unsigned b, h;
        if (!rfm) return alu;
        b = (longint'(word) >> (8 * alu[1:0])) % 256;
        h = (longint'(word) >> (16 * (alu[1:0] / 2))) % 65536;
        case (op)
            3'd1: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd2: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd3: return 32'(b);
            3'd4: return 32'(h);
            default: return word;
        endcase
    endfunction

    logic        m_valid, m_entry, m_we, m_rfm;
    logic [31:0] m_pc, m_alu, m_word, m_res;
    logic [2:0]  m_op;
    logic [4:0]  m_dest;
    logic        ev, wb;

    initial begin
        vecs[0] = '{3'd1, 32'h0000_1003, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80};
        vecs[1] = '{3'd4, 32'h0000_2002, 32'h8001_7FFF, 1'b1, 32'h0000_8001};
        vecs[2] = '{3'd2, 32'h0000_2002, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001};
        vecs[3] = '{3'd0, 32'h0000_3001, 32'h1234_5678, 1'b1, 32'h1234_5678};
        vecs[4] = '{3'd3, 32'h0000_0001, 32'h0000_A500, 1'b1, 32'h0000_00A5};
        vecs[5] = '{3'd1, 32'h0000_0000, 32'hFFFF_FF7F, 1'b1, 32'h0000_007F};
        vecs[6] = '{3'd5, 32'h0000_0002, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vecs[7] = '{3'd1, 32'h0000_4443, 32'hFFFF_FFFF, 1'b0, 32'h0000_4443};
        vecs[8] = '{3'd2, 32'h0000_0001, 32'h1234_F00D, 1'b1, 32'hFFFF_F00D};
        vecs[9] = '{3'd4, 32'h0000_0003, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF};

        reset = 1'b1;
        WB_allow_in = 1'b1;
        data_sram_rdata = 32'h0;
        put(1'b1, 32'h1111_2222, 3'd0, 1'b0, 1'b1, 5'd7, 32'h5555_AAAA);
        tick();
        tick();
        reset = 1'b0;
        EXE_to_MEM_valid = 1'b0;
        #1;
        chk("reset_valid", 70'(MEM_to_WB_valid), 70'd0);
        chk("reset_wb",    70'(MEM_WB_reg),      70'd0);
        chk("reset_fwd",   70'(MEM_fwd_bus),     70'd0);
        chk("reset_allow", 70'(MEM_allow_in),    70'd1);

        for (int i = 0; i < 10; i++) begin
            put(1'b1, 32'h8000_0000 + 32'(i), vecs[i].op, vecs[i].rfm, 1'b1, 5'(i + 1), vecs[i].alu);
            tick();
            EXE_to_MEM_valid = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_valid", i), 70'(MEM_to_WB_valid), 70'd1);
            chk($sformatf("vec%0d_wb", i), 70'(MEM_WB_reg),
                {32'h8000_0000 + 32'(i), 1'b1, 5'(i + 1), vecs[i].exp});
        end

        // Stall with entry-cycle data captured, then released.
        tick();
        put(1'b1, 32'h0000_0040, 3'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0100);
        tick();
        put(1'b1, 32'h0000_0044, 3'd0, 1'b0, 1'b1, 5'd10, 32'h0000_0999);
        data_sram_rdata = 32'hDEAD_BEEF;
        WB_allow_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall%0d_data", s), 70'(MEM_WB_reg[31:0]), 70'h0DEAD_BEEF);
            chk($sformatf("stall%0d_allow", s), 70'(MEM_allow_in), 70'd0);
            tick();
            data_sram_rdata = 32'h0;
        end
        WB_allow_in = 1'b1;
        EXE_to_MEM_valid = 1'b0;
        #1;
        chk("stall_release_data", 70'(MEM_WB_reg), {32'h0000_0040, 1'b1, 5'd9, 32'hDEAD_BEEF});
        chk("stall_release_allow", 70'(MEM_allow_in), 70'd1);
        tick();
        chk("stall_drain", 70'(MEM_to_WB_valid), 70'd0);

        // Three ALU results back-to-back.
        for (int k = 1; k <= 4; k++) begin
            if (k <= 3) put(1'b1, 32'(k * 4), 3'd0, 1'b0, 1'b1, 5'(k), 32'(k * 32'h100));
            else        EXE_to_MEM_valid = 1'b0;
            if (k > 1) begin
                #1;
                chk($sformatf("b2b%0d_valid", k - 1), 70'(MEM_to_WB_valid), 70'd1);
                chk($sformatf("b2b%0d_fwd", k - 1), 70'(MEM_fwd_bus),
                    70'({1'b1, 5'(k - 1), 32'((k - 1) * 32'h100)}));
            end
            tick();
        end
        chk("b2b_end", 70'(MEM_to_WB_valid), 70'd0);

        // Reset mid-operation overrides a simultaneous incoming instruction.
        put(1'b1, 32'h0000_0200, 3'd0, 1'b0, 1'b1, 5'd4, 32'h0000_0777);
        tick();
        chk("mid_valid_before", 70'(MEM_to_WB_valid), 70'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        EXE_to_MEM_valid = 1'b0;
        #1;
        chk("mid_reset_valid", 70'(MEM_to_WB_valid), 70'd0);
        chk("mid_reset_fwd",   70'(MEM_fwd_bus),     70'd0);
        chk("mid_reset_allow", 70'(MEM_allow_in),    70'd1);

        // Random traffic; the model tracks the word seen in the entry cycle.
        do_reset();
        m_valid = 1'b0;
        m_entry = 1'b0;
        m_word  = 32'h0;
        for (int c = 0; c < 400; c++) begin
            ev = ($urandom_range(0, 3) != 0);
            wb = ($urandom_range(0, 3) != 0);
            WB_allow_in = wb;
            data_sram_rdata = $urandom;
            put(ev, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom), $urandom);
            #1;
            chk("rnd_allow", 70'(MEM_allow_in), 70'(!m_valid || wb));
            chk("rnd_valid", 70'(MEM_to_WB_valid), 70'(m_valid));
            if (m_valid) begin
                m_res = ref_final(m_op, m_alu, m_entry ? data_sram_rdata : m_word, m_rfm);
                chk("rnd_wb", 70'(MEM_WB_reg), {m_pc, m_we, m_dest, m_res});
                chk("rnd_fwd", 70'(MEM_fwd_bus), 70'({m_we, m_dest, m_res}));
            end else begin
                chk("rnd_fwd_we", 70'(MEM_fwd_bus[37]), 70'd0);
            end
            if (m_entry) m_word = data_sram_rdata;
            if (!m_valid || wb) begin
                m_valid = ev;
                m_entry = ev;
                if (ev) begin
                    {m_pc, m_op, m_rfm, m_we, m_dest, m_alu} = EXE_MEM_reg;
                end
            end else begin
                m_entry = 1'b0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
